// File: rtl/pause_ctrl_multi.sv
// pause_ctrl_multi: merges N pause requesters, the user button and OSD pause into a
// registered pause_cpu, runs a dim-after-timeout timer and dims RGB while paused.
// Optional frame stepping is compiled in when PAUSE_FRAME_STEP_EN is defined.
module pause_ctrl_multi #(
    parameter int RW       = 3,
    parameter int GW       = 3,
    parameter int BW       = 3,
    parameter int NREQ     = 2,
    parameter int CLKSPD   = 40,
    parameter int TICK_DIV = 1000000,
    parameter int DIM_SEC  = 10
) (
    input  logic                   clk_sys,
    input  logic                   reset_n,
    input  logic                   user_button,
    input  logic                   step_button,
    input  logic [NREQ-1:0]        pause_req,
    input  logic                   OSD_STATUS,
    input  logic [1:0]             options,
    input  logic                   vblank,
    input  logic [RW-1:0]          r,
    input  logic [GW-1:0]          g,
    input  logic [BW-1:0]          b,
    output logic                   pause_cpu,
    output logic [NREQ+1:0]        pause_src,
    output logic                   dim_active,
    output logic [RW+GW+BW-1:0]    rgb_out
);
    localparam int PERIOD = CLKSPD * TICK_DIV;
    localparam int PW     = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam int SW     = RW + GW + BW;
    localparam logic [NREQ+1:0] USER_ONLY = {{(NREQ+1){1'b0}}, 1'b1};

    logic            ub_q;
    logic            user_pause_q, user_pause_d;
    logic [NREQ+1:0] src;
    logic [NREQ+1:0] pause_src_q;
    logic            pause_cpu_q, pause_cpu_d;
    logic            dim_q, dim_d;
    logic [PW-1:0]   presc_q, presc_d;
    logic [7:0]      sec_q, sec_d;
    logic [SW-1:0]   rgb_q, rgb_d;
    logic            step_run;
    logic            wrap;

    assign user_pause_d = user_pause_q ^ (user_button & ~ub_q);
    assign src          = {pause_req, OSD_STATUS & options[0], user_pause_q};
    assign pause_cpu_d  = (|src) & ~step_run;
    assign wrap         = (presc_q == PW'(PERIOD - 1));

`ifdef PAUSE_FRAME_STEP_EN
    logic sb_q, vb_q;
    logic step_run_q, step_run_d;
    logic vcnt_q, vcnt_d;

    assign step_run = step_run_q;

    // Accept a step only under sole user pause; end it on the second vblank rise.
    always_comb begin
        step_run_d = step_run_q;
        vcnt_d     = vcnt_q;
        if (step_run_q) begin
            if (src != USER_ONLY) begin
                step_run_d = 1'b0;
                vcnt_d     = 1'b0;
            end else if (vblank & ~vb_q) begin
                step_run_d = ~vcnt_q;
                vcnt_d     = ~vcnt_q;
            end
        end else if (step_button & ~sb_q & (src == USER_ONLY)) begin
            step_run_d = 1'b1;
            vcnt_d     = 1'b0;
        end
    end

    // Step edge detectors and step state.
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            sb_q       <= 1'b0;
            vb_q       <= 1'b0;
            step_run_q <= 1'b0;
            vcnt_q     <= 1'b0;
        end else begin
            sb_q       <= step_button;
            vb_q       <= vblank;
            step_run_q <= step_run_d;
            vcnt_q     <= vcnt_d;
        end
    end
`else
    logic unused_step;

    assign step_run    = 1'b0;
    assign unused_step = step_button ^ vblank ^ USER_ONLY[0];
`endif

    // Dim timer: prescaler and saturating seconds run only while paused and not stepping.
    always_comb begin
        presc_d = '0;
        sec_d   = '0;
        dim_d   = 1'b0;
        if (pause_cpu_q & ~step_run) begin
            presc_d = wrap ? '0 : presc_q + 1'b1;
            sec_d   = (wrap && sec_q != 8'(DIM_SEC)) ? sec_q + 8'd1 : sec_q;
            dim_d   = pause_cpu_d & options[1] & (sec_d == 8'(DIM_SEC));
        end
    end

    // RGB pass-through, halving each channel independently while dimmed.
    always_comb begin
        rgb_d = dim_q ? {r >> 1, g >> 1, b >> 1} : {r, g, b};
    end

    // Main state and output registers.
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            ub_q         <= 1'b0;
            user_pause_q <= 1'b0;
            pause_src_q  <= '0;
            pause_cpu_q  <= 1'b0;
            dim_q        <= 1'b0;
            presc_q      <= '0;
            sec_q        <= '0;
            rgb_q        <= '0;
        end else begin
            ub_q         <= user_button;
            user_pause_q <= user_pause_d;
            pause_src_q  <= src;
            pause_cpu_q  <= pause_cpu_d;
            dim_q        <= dim_d;
            presc_q      <= presc_d;
            sec_q        <= sec_d;
            rgb_q        <= rgb_d;
        end
    end

    assign pause_cpu  = pause_cpu_q;
    assign pause_src  = pause_src_q;
    assign dim_active = dim_q;
    assign rgb_out    = rgb_q;
endmodule

// File: tb/tb_pause_ctrl_multi.sv
// tb_pause_ctrl_multi: directed and randomized checks against a cycle-level behavioural model.
module tb_pause_ctrl_multi;
    localparam int RW = 3, GW = 3, BW = 3, NREQ = 2;
    localparam int CLKSPD = 4, TICK_DIV = 1, DIM_SEC = 2;
    localparam int DIM_CYC = CLKSPD * TICK_DIV * DIM_SEC;

    logic            clk_sys = 0, reset_n = 0, user_button = 0, step_button = 0;
    logic            OSD_STATUS = 0, vblank = 0;
    logic [NREQ-1:0] pause_req = '0;
    logic [1:0]      options = '0;
    logic [RW-1:0]   r = '0;
    logic [GW-1:0]   g = '0;
    logic [BW-1:0]   b = '0;
    logic            pause_cpu, dim_active;
    logic [NREQ+1:0] pause_src;
    logic [8:0]      rgb_out;

    int tests = 0, fails = 0;
    bit chk_en = 0;

    bit              m_user, m_ub, m_pause, m_dim, m_step, m_vcnt, m_sb, m_vb;
    logic [NREQ+1:0] m_src;
    logic [8:0]      m_rgb;
    int              run_len;

    always #5 clk_sys = ~clk_sys;

    pause_ctrl_multi #(.RW(RW), .GW(GW), .BW(BW), .NREQ(NREQ), .CLKSPD(CLKSPD),
                       .TICK_DIV(TICK_DIV), .DIM_SEC(DIM_SEC)) dut (
        .clk_sys(clk_sys), .reset_n(reset_n), .user_button(user_button),
        .step_button(step_button), .pause_req(pause_req), .OSD_STATUS(OSD_STATUS),
        .options(options), .vblank(vblank), .r(r), .g(g), .b(b),
        .pause_cpu(pause_cpu), .pause_src(pause_src), .dim_active(dim_active),
        .rgb_out(rgb_out)
    );

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        tests++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk_sys);
        #2;
    endtask

    // Behavioural model: dim after DIM_CYC consecutive live paused cycles.
    always @(posedge clk_sys) begin : model
        logic [NREQ+1:0] s;
        bit live, np;
        if (!reset_n) begin
            {m_user, m_ub, m_pause, m_dim, m_step, m_vcnt, m_sb, m_vb} = '0;
            m_src = '0;
            m_rgb = '0;
            run_len = 0;
        end else begin
            s = {pause_req, OSD_STATUS & options[0], m_user};
            live = m_pause && !m_step;
            run_len = live ? run_len + 1 : 0;
            np = (s != 0) && !m_step;
            m_rgb = m_dim ? {3'(r / 2), 3'(g / 2), 3'(b / 2)} : {r, g, b};
            m_dim = live && np && options[1] && (run_len >= DIM_CYC);
            m_pause = np;
            m_src = s;
`ifdef PAUSE_FRAME_STEP_EN
            if (m_step) begin
                if (s != (NREQ+2)'(1)) begin
                    m_step = 0;
                    m_vcnt = 0;
                end else if (vblank && !m_vb) begin
                    if (m_vcnt) begin
                        m_step = 0;
                        m_vcnt = 0;
                    end else m_vcnt = 1;
                end
            end else if (step_button && !m_sb && s == (NREQ+2)'(1)) begin
                m_step = 1;
                m_vcnt = 0;
            end
            m_sb = step_button;
            m_vb = vblank;
`endif
            if (user_button && !m_ub) m_user = !m_user;
            m_ub = user_button;
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk_sys) begin
        if (chk_en) begin
            chk("m_pause_cpu", pause_cpu, m_pause);
            chk("m_pause_src", pause_src, m_src);
            chk("m_dim_active", dim_active, m_dim);
            chk("m_rgb_out", rgb_out, m_rgb);
        end
    end

    initial begin
        reset_n = 0; user_button = 1; r = 7;
        tick(1);
        chk_en = 1;
        tick(2);
        chk("rst_pause_cpu", pause_cpu, 0);
        chk("rst_pause_src", pause_src, 0);
        chk("rst_dim", dim_active, 0);
        chk("rst_rgb", rgb_out, 0);
        user_button = 0; reset_n = 1; {r, g, b} = 9'h1FF;
        tick(1);
        chk("rgb_pass", rgb_out, 9'h1FF);

        user_button = 1;
        tick(1); chk("user_lat1", pause_cpu, 0);
        tick(1); chk("user_lat2", pause_cpu, 1);
        tick(48); chk("user_hold", pause_cpu, 1); chk("user_src", pause_src, 4'b0001);
        user_button = 0; tick(5);
        user_button = 1;
        tick(1); chk("user_off1", pause_cpu, 1);
        tick(1); chk("user_off2", pause_cpu, 0);
        user_button = 0; tick(2);

        options = 2'b10; pause_req = 2'b10; {r, g, b} = {3'd7, 3'd5, 3'd3};
        tick(1); chk("dim_pause", pause_cpu, 1);
        tick(7); chk("dim_early", dim_active, 0);
        tick(1); chk("dim_on", dim_active, 1);
        tick(1); chk("dim_rgb", rgb_out, 9'h0D1);
        pause_req = 0;
        tick(1); chk("drop_pause", pause_cpu, 0); chk("drop_dim", dim_active, 0);
        pause_req = 2'b10;
        tick(1); chk("repause", pause_cpu, 1);
        tick(7); chk("restart_early", dim_active, 0);
        tick(1); chk("restart_on", dim_active, 1);
        options = 2'b00; tick(1); chk("opt_off", dim_active, 0);
        options = 2'b10; tick(1); chk("opt_on", dim_active, 1);
        pause_req = 0; options = 0; tick(2);

        OSD_STATUS = 1;
        tick(1); chk("osd_noopt", pause_cpu, 0);
        options = 2'b01;
        tick(1); chk("osd_pause", pause_cpu, 1); chk("osd_src", pause_src, 4'b0010);
        pause_req = 2'b01;
        tick(1); chk("osd_req_src", pause_src, 4'b0110);
        OSD_STATUS = 0; pause_req = 0; options = 0; tick(2);

        user_button = 1; tick(1); user_button = 0; pause_req = 2'b01; tick(3);
        user_button = 1;
        tick(2); chk("sim_pause", pause_cpu, 1); chk("sim_src", pause_src, 4'b0100);
        user_button = 0; pause_req = 0;
        tick(2); chk("sim_release", pause_cpu, 0);

`ifdef PAUSE_FRAME_STEP_EN
        user_button = 1; tick(1); user_button = 0; tick(2);
        chk("step_pre", pause_cpu, 1);
        step_button = 1; tick(1); step_button = 0;
        tick(1); chk("step_run", pause_cpu, 0);
        vblank = 1; tick(1); vblank = 0; tick(3);
        chk("step_mid", pause_cpu, 0);
        vblank = 1; tick(1); vblank = 0;
        tick(1); chk("step_back", pause_cpu, 1);
        pause_req = 2'b01; step_button = 1; tick(1); step_button = 0;
        tick(2); chk("step_blocked", pause_cpu, 1);
        pause_req = 0; user_button = 1; tick(1); user_button = 0; tick(2);
`endif

        repeat (4000) begin
            if ($urandom_range(0, 15) == 0) user_button = ~user_button;
            if ($urandom_range(0, 7) == 0) step_button = ~step_button;
            if ($urandom_range(0, 5) == 0) vblank = ~vblank;
            if ($urandom_range(0, 39) == 0) pause_req[0] = ~pause_req[0];
            if ($urandom_range(0, 39) == 0) pause_req[1] = ~pause_req[1];
            if ($urandom_range(0, 29) == 0) OSD_STATUS = ~OSD_STATUS;
            if ($urandom_range(0, 49) == 0) options = 2'($urandom_range(0, 3));
            {r, g, b} = 9'($urandom);
            reset_n = ($urandom_range(0, 499) != 0);
            tick(1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
